// File: rtl/regfile_wb_if.sv
// Bus between the W pipeline register / decode stage and the writeback register file.
interface regfile_wb_if #(
  parameter int DW    = 8,
  parameter int NREG  = 8,
  parameter int CNT_W = 16
);
  localparam int AW = $clog2(NREG);

  logic [DW-1:0]    RD1W;
  logic [DW-1:0]    ALUResultW;
  logic [DW-1:0]    ReadDataW;
  logic [AW-1:0]    WA3W;
  logic [AW-1:0]    WA4W;
  logic             RegWriteAW;
  logic             RegWriteBW;
  logic             MemtoRegW;
  logic [AW-1:0]    RA1D;
  logic [AW-1:0]    RA2D;
  logic [DW-1:0]    RD1D;
  logic [DW-1:0]    RD2D;
  logic [DW-1:0]    ResultW;
  logic [AW-1:0]    DbgAddr;
  logic [DW-1:0]    DbgData;
  logic [CNT_W-1:0] CommitCnt;

  modport master (
    output RD1W, ALUResultW, ReadDataW, WA3W, WA4W, RegWriteAW, RegWriteBW,
    output MemtoRegW, RA1D, RA2D, DbgAddr,
    input  RD1D, RD2D, ResultW, DbgData, CommitCnt
  );

  modport slave (
    input  RD1W, ALUResultW, ReadDataW, WA3W, WA4W, RegWriteAW, RegWriteBW,
    input  MemtoRegW, RA1D, RA2D, DbgAddr,
    output RD1D, RD2D, ResultW, DbgData, CommitCnt
  );
endinterface

// File: rtl/regfile_wb.sv
// Writeback stage and architectural register file: MemtoReg select, two write
// ports (A = result, B = RD1 for swap/move), bypassed decode reads, registered
// debug read and a retired-write counter.
module regfile_wb #(
  parameter int DW      = 8,
  parameter int NREG    = 8,
  parameter bit R0_ZERO = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  regfile_wb_if.slave  bus
);
  localparam int AW = $clog2(NREG);

  logic [DW-1:0] regs [NREG];
  logic          weA;
  logic          weB;
  logic          aToZero;
  logic          bToZero;
  logic          collide;

  // Writeback result select
  always_comb begin
    bus.ResultW = bus.MemtoRegW ? bus.ReadDataW : bus.ALUResultW;
  end

  // Effective write enables after R0 discard and A-over-B collision filtering;
  // enables gate every address compare so X on an idle port cannot leak through
  always_comb begin
    aToZero = R0_ZERO && (bus.WA3W == '0);
    bToZero = R0_ZERO && (bus.WA4W == '0);
    collide = bus.RegWriteAW && bus.RegWriteBW && (bus.WA3W == bus.WA4W);
    weA     = bus.RegWriteAW && !aToZero;
    weB     = bus.RegWriteBW && !bToZero && !collide;
  end

  // Register array; port B is dropped on collision so each entry has one writer per cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (weA) begin
        regs[bus.WA3W] <= bus.ResultW;
      end
      if (weB) begin
        regs[bus.WA4W] <= bus.RD1W;
      end
    end
  end

  // Decode read port 1 with write-through bypass, A has priority like the collision rule
  always_comb begin
    bus.RD1D = regs[bus.RA1D];
    if (R0_ZERO && (bus.RA1D == '0)) begin
      bus.RD1D = '0;
    end else if (bus.RegWriteAW && (bus.WA3W == bus.RA1D)) begin
      bus.RD1D = bus.ResultW;
    end else if (bus.RegWriteBW && (bus.WA4W == bus.RA1D)) begin
      bus.RD1D = bus.RD1W;
    end
  end

  // Decode read port 2 with the same bypass rules
  always_comb begin
    bus.RD2D = regs[bus.RA2D];
    if (R0_ZERO && (bus.RA2D == '0)) begin
      bus.RD2D = '0;
    end else if (bus.RegWriteAW && (bus.WA3W == bus.RA2D)) begin
      bus.RD2D = bus.ResultW;
    end else if (bus.RegWriteBW && (bus.WA4W == bus.RA2D)) begin
      bus.RD2D = bus.RD1W;
    end
  end

  // Debug read samples the pre-write array contents, no bypass
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.DbgData <= '0;
    end else begin
      bus.DbgData <= regs[bus.DbgAddr];
    end
  end

  // Commit counter advances by the number of effective writes and wraps naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.CommitCnt <= '0;
    end else begin
      bus.CommitCnt <= bus.CommitCnt + CNT_W'(weA) + CNT_W'(weB);
    end
  end

  logic unusedAw;
  assign unusedAw = (AW == 0);
endmodule
